scan_select_seq: RTL and testbench

//  Sequencer that drives the A/B/C select inputs of the dual 2-to-4 decoder stage.

---
 rtl/scan_select_seq.sv | 178 +++++++++++++++++
 tb/tb_scan_select_seq.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/scan_select_seq.sv
// scan_select_seq: steps a 3-bit channel index over the channels enabled in
// MASK, holding each for DWELL+1 clocks, and presents it as the C/B/A select
// bits of a dual 2-to-4 decoder. Continuous (RUN) or single-frame (START).
module scan_select_seq #(
    parameter int DWELL_W = 8
) (
    input  logic               CLK,
    input  logic               CLR_L,
    input  logic               RUN,
    input  logic               START,
    input  logic [DWELL_W-1:0] DWELL,
    input  logic [7:0]         MASK,
    output logic               A,
    output logic               B,
    output logic               C,
    output logic               VALID,
    output logic               STEP,
    output logic               FRAME,
    output logic               BUSY
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // Lowest set bit of mask at or above position lo; MSB of result = found.
    function automatic logic [3:0] lowest_from(input logic [7:0] mask, input logic [3:0] lo);
        logic [3:0] res;
        res = 4'b0000;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i] && (4'(i) >= lo)) begin
                res = {1'b1, 3'(i)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    state_t             state_q, state_d;
    logic [2:0]         ch_q, ch_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               cont_q, cont_d;
    logic               valid_q, valid_d;
    logic               step_q, step_d;
    logic               frame_q, frame_d;
    logic               busy_q, busy_d;

    logic       mask_nz_s;
    logic       req_s;
    logic       expire_s;
    logic       reload_s;
    logic [3:0] first_s;
    logic [3:0] nxt_s;

    assign mask_nz_s = (MASK != 8'h00);
    assign req_s     = (RUN | START) & mask_nz_s;
    assign expire_s  = (cnt_q == {DWELL_W{1'b0}});
    assign reload_s  = cont_q & RUN & mask_nz_s;
    assign first_s   = lowest_from(MASK, 4'd0);
    // Search strictly above the current channel; ch=7 yields 8, i.e. nothing.
    assign nxt_s     = lowest_from(MASK, {1'b0, ch_q} + 4'd1);

    // State register: IDLE on reset.
    always_ff @(posedge CLK or negedge CLR_L) begin
        if (!CLR_L) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode: leave IDLE on a valid request, return at frame end
    // unless a continuous scan is still requested with a non-empty mask.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_s) begin
                    state_d = SCAN;
                end else begin
                    state_d = IDLE;
                end
            end
            SCAN: begin
                if (expire_s && !nxt_s[3] && !reload_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = SCAN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output decode: channel loads, dwell countdown and the
    // registered STEP/FRAME/VALID/BUSY values for the following cycle.
    always_comb begin
        ch_d    = ch_q;
        cnt_d   = cnt_q;
        cont_d  = cont_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        step_d  = 1'b0;
        frame_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_s) begin
                    ch_d    = first_s[2:0];
                    cnt_d   = DWELL;
                    cont_d  = RUN;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    step_d  = 1'b1;
                end else begin
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                end
            end
            SCAN: begin
                if (!expire_s) begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end else if (nxt_s[3]) begin
                    ch_d   = nxt_s[2:0];
                    cnt_d  = DWELL;
                    step_d = 1'b1;
                end else begin
                    frame_d = 1'b1;
                    if (reload_s) begin
                        ch_d   = first_s[2:0];
                        cnt_d  = DWELL;
                        step_d = 1'b1;
                    end else begin
                        // ch and A/B/C keep their last value in IDLE.
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Datapath and output registers; reset clears everything, so an aborted
    // scan never produces a FRAME pulse.
    always_ff @(posedge CLK or negedge CLR_L) begin
        if (!CLR_L) begin
            ch_q    <= 3'd0;
            cnt_q   <= {DWELL_W{1'b0}};
            cont_q  <= 1'b0;
            valid_q <= 1'b0;
            step_q  <= 1'b0;
            frame_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            ch_q    <= ch_d;
            cnt_q   <= cnt_d;
            cont_q  <= cont_d;
            valid_q <= valid_d;
            step_q  <= step_d;
            frame_q <= frame_d;
            busy_q  <= busy_d;
        end
    end

    assign A     = ch_q[0];
    assign B     = ch_q[1];
    assign C     = ch_q[2];
    assign VALID = valid_q;
    assign STEP  = step_q;
    assign FRAME = frame_q;
    assign BUSY  = busy_q;

endmodule

// File: tb/tb_scan_select_seq.sv
// Directed bench for scan_select_seq: expected per-cycle outputs are queued
// as stimulus is applied and popped when the DUT is sampled.
module tb_scan_select_seq;

    typedef struct packed {
        logic       valid;
        logic       busy;
        logic       step;
        logic       frame;
        logic [2:0] ch;
    } exp_t;

    logic       clk;
    logic       clr_l;
    logic       run;
    logic       start;
    logic [7:0] dwell;
    logic [7:0] mask;
    logic       a, b, c, valid, step, frame, busy;

    exp_t q[$];
    int   checks;
    int   failures;

    scan_select_seq #(.DWELL_W(8)) dut (
        .CLK  (clk),
        .CLR_L(clr_l),
        .RUN  (run),
        .START(start),
        .DWELL(dwell),
        .MASK (mask),
        .A    (a),
        .B    (b),
        .C    (c),
        .VALID(valid),
        .STEP (step),
        .FRAME(frame),
        .BUSY (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input logic v, input logic bz, input logic s, input logic f, input int ch);
        exp_t e;
        e.valid = v;
        e.busy  = bz;
        e.step  = s;
        e.frame = f;
        e.ch    = 3'(ch);
        q.push_back(e);
    endtask

    // Pop the oldest expectation and compare against the current outputs.
    task automatic check_now(input string tag);
        exp_t obs;
        exp_t exp_v;
        obs = {valid, busy, step, frame, c, b, a};
        checks++;
        if (q.size() == 0) begin
            failures++;
            $error("FAIL %s scoreboard empty observed=%b", tag, obs);
        end else begin
            exp_v = q.pop_front();
            assert (obs === exp_v) else begin
                failures++;
                $error("FAIL %s observed(v,bz,st,fr,cba)=%b expected=%b", tag, obs, exp_v);
            end
        end
    endtask

    // Advance one clock and check just after the edge.
    task automatic tick(input string tag);
        @(posedge clk);
        #1;
        check_now(tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int chs[3];
        checks   = 0;
        failures = 0;
        clr_l = 1'b0;
        run   = 1'b0;
        start = 1'b0;
        dwell = 8'd0;
        mask  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        push(1'b0, 1'b0, 1'b0, 1'b0, 0);
        check_now("reset");
        clr_l = 1'b1;

        // 1: MASK=FF, DWELL=0, START -> ch 0..7 one cycle each, then FRAME.
        mask  = 8'hFF;
        dwell = 8'd0;
        start = 1'b1;
        push(1'b1, 1'b1, 1'b1, 1'b0, 0);
        tick("t1_load");
        start = 1'b0;
        for (int i = 1; i < 8; i++) begin
            push(1'b1, 1'b1, 1'b1, 1'b0, i);
            tick("t1_step");
        end
        push(1'b0, 1'b0, 1'b0, 1'b1, 7);
        tick("t1_frame");
        push(1'b0, 1'b0, 1'b0, 1'b0, 7);
        tick("t1_idle");

        // 2: MASK=1010_0100, DWELL=2, RUN -> 2,5,7 x3 cycles, FRAME every 9.
        mask  = 8'b1010_0100;
        dwell = 8'd2;
        run   = 1'b1;
        chs[0] = 2; chs[1] = 5; chs[2] = 7;
        for (int f = 0; f < 2; f++) begin
            for (int j = 0; j < 3; j++) begin
                for (int k = 0; k < 3; k++) begin
                    push(1'b1, 1'b1, k == 0, (k == 0) && (j == 0) && (f > 0), chs[j]);
                    tick("t2_scan");
                    if (f == 1) run = 1'b0;
                end
            end
        end
        push(1'b0, 1'b0, 1'b0, 1'b1, 7);
        tick("t2_frame");

        // 3: RUN, DWELL=1, MASK=FF; drop RUN at ch=3 -> finish 4..7, no reload.
        mask  = 8'hFF;
        dwell = 8'd1;
        run   = 1'b1;
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 2; k++) begin
                push(1'b1, 1'b1, k == 0, 1'b0, i);
                tick("t3_scan");
                if (i == 3 && k == 0) run = 1'b0;
            end
        end
        push(1'b0, 1'b0, 1'b0, 1'b1, 7);
        tick("t3_frame");
        push(1'b0, 1'b0, 1'b0, 1'b0, 7);
        tick("t3_idle");

        // 4: MASK=00 with START, then with RUN -> stays idle.
        mask  = 8'h00;
        start = 1'b1;
        push(1'b0, 1'b0, 1'b0, 1'b0, 7);
        tick("t4_start");
        start = 1'b0;
        run   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push(1'b0, 1'b0, 1'b0, 1'b0, 7);
            tick("t4_run");
        end
        run = 1'b0;

        // 5: MASK=FF, DWELL=3, START; at ch=2 MASK=0F and START again.
        mask  = 8'hFF;
        dwell = 8'd3;
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 4; k++) begin
                push(1'b1, 1'b1, k == 0, 1'b0, i);
                tick("t5_scan");
                start = 1'b0;
                if (i == 2 && k == 0) begin
                    mask  = 8'h0F;
                    start = 1'b1;
                end
            end
        end
        push(1'b0, 1'b0, 1'b0, 1'b1, 3);
        tick("t5_frame");
        push(1'b0, 1'b0, 1'b0, 1'b0, 3);
        tick("t5_idle");

        // 6: asynchronous reset mid-dwell at ch=5, then restart.
        mask  = 8'hFF;
        dwell = 8'd1;
        start = 1'b1;
        for (int i = 0; i < 6; i++) begin
            push(1'b1, 1'b1, 1'b1, 1'b0, i);
            tick("t6_scan");
            start = 1'b0;
            if (i < 5) begin
                push(1'b1, 1'b1, 1'b0, 1'b0, i);
                tick("t6_hold");
            end
        end
        #2;
        clr_l = 1'b0;
        #1;
        push(1'b0, 1'b0, 1'b0, 1'b0, 0);
        check_now("t6_async_clr");
        push(1'b0, 1'b0, 1'b0, 1'b0, 0);
        tick("t6_in_reset");
        #2;
        clr_l = 1'b1;
        mask  = 8'b0011_0000;
        start = 1'b1;
        push(1'b1, 1'b1, 1'b1, 1'b0, 4);
        tick("t6_restart");
        start = 1'b0;
        push(1'b1, 1'b1, 1'b0, 1'b0, 4);
        tick("t6_r_hold");
        push(1'b1, 1'b1, 1'b1, 1'b0, 5);
        tick("t6_r_step");
        push(1'b1, 1'b1, 1'b0, 1'b0, 5);
        tick("t6_r_hold5");
        push(1'b0, 1'b0, 1'b0, 1'b1, 5);
        tick("t6_r_frame");

        // 7: DWELL=max on a single channel -> 256 cycles, then FRAME.
        mask  = 8'h01;
        dwell = 8'hFF;
        start = 1'b1;
        for (int k = 0; k < 256; k++) begin
            push(1'b1, 1'b1, k == 0, 1'b0, 0);
            tick("t7_dwell_max");
            start = 1'b0;
        end
        push(1'b0, 1'b0, 1'b0, 1'b1, 0);
        tick("t7_frame");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
